// File: rtl/vga_ctrl_if.sv
// Drawing-engine write port and VGA DAC pins of the frame-buffered VGA controller.
// The drawing/pattern side is the master; the controller is the slave.
interface vga_ctrl_if;
  logic [7:0] write_x;
  logic [7:0] write_y;
  logic [2:0] write_r;
  logic [2:0] write_g;
  logic [2:0] write_b;
  logic [3:0] oVGA_R;
  logic [3:0] oVGA_G;
  logic [3:0] oVGA_B;
  logic       oVGA_HS;
  logic       oVGA_VS;

  modport master (
    output write_x, write_y, write_r, write_g, write_b,
    input  oVGA_R, oVGA_G, oVGA_B, oVGA_HS, oVGA_VS
  );

  modport slave (
    input  write_x, write_y, write_r, write_g, write_b,
    output oVGA_R, oVGA_G, oVGA_B, oVGA_HS, oVGA_VS
  );
endinterface

// File: rtl/vga_ctrl.sv
// 160x120 RGB333 framebuffer scanned out as 640x480@60 VGA with 4x4 pixel scaling.
// Sync and blank ride the same two-tick pipeline as the memory read so the pins stay aligned.
module vga_ctrl (
  input  logic      iCLK,
  input  logic      iRST,
  vga_ctrl_if.slave vga
);

  localparam logic [9:0] H_LAST    = 10'd799;
  localparam logic [9:0] V_LAST    = 10'd524;
  localparam logic [9:0] H_VISIBLE = 10'd640;
  localparam logic [9:0] V_VISIBLE = 10'd480;
  localparam logic [9:0] HS_FIRST  = 10'd656;
  localparam logic [9:0] HS_LAST   = 10'd751;
  localparam logic [9:0] VS_FIRST  = 10'd490;
  localparam logic [9:0] VS_LAST   = 10'd491;

  logic [8:0]  r_mem [0:19199];
  logic [8:0]  r_rdata;
  logic        r_tick;
  logic [9:0]  r_hcnt;
  logic [9:0]  r_vcnt;
  logic        r_vis1;
  logic        r_hs1;
  logic        r_vs1;
  logic [3:0]  r_red;
  logic [3:0]  r_grn;
  logic [3:0]  r_blu;
  logic        r_hs;
  logic        r_vs;

  logic        w_wen;
  logic        w_vis;
  logic        w_hs;
  logic        w_vs;
  logic [14:0] w_waddr;
  logic [14:0] w_raddr;

  assign w_wen   = !iRST && (vga.write_x < 8'd160) && (vga.write_y < 8'd120);
  assign w_waddr = ({7'd0, vga.write_y} * 15'd160) + {7'd0, vga.write_x};

  assign w_vis = (r_hcnt < H_VISIBLE) && (r_vcnt < V_VISIBLE);
  assign w_hs  = !((r_hcnt >= HS_FIRST) && (r_hcnt <= HS_LAST));
  assign w_vs  = !((r_vcnt >= VS_FIRST) && (r_vcnt <= VS_LAST));

  // Off-screen positions read address 0; that data is blanked before the pins.
  assign w_raddr = w_vis ? (({7'd0, r_vcnt[9:2]} * 15'd160) + {7'd0, r_hcnt[9:2]})
                         : 15'd0;

  always_ff @(posedge iCLK) begin
    if (w_wen) begin
      r_mem[w_waddr] <= {vga.write_r, vga.write_g, vga.write_b};
    end
    if (r_tick) begin
      r_rdata <= r_mem[w_raddr];
    end
  end

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      r_tick <= 1'b0;
      r_hcnt <= 10'd0;
      r_vcnt <= 10'd0;
      r_vis1 <= 1'b0;
      r_hs1  <= 1'b1;
      r_vs1  <= 1'b1;
      r_red  <= 4'd0;
      r_grn  <= 4'd0;
      r_blu  <= 4'd0;
      r_hs   <= 1'b1;
      r_vs   <= 1'b1;
    end else begin
      r_tick <= ~r_tick;
      if (r_tick) begin
        if (r_hcnt == H_LAST) begin
          r_hcnt <= 10'd0;
          r_vcnt <= (r_vcnt == V_LAST) ? 10'd0 : r_vcnt + 10'd1;
        end else begin
          r_hcnt <= r_hcnt + 10'd1;
        end
        r_vis1 <= w_vis;
        r_hs1  <= w_hs;
        r_vs1  <= w_vs;
        // Each 3-bit component widens to 4 bits by repeating its MSB.
        r_red  <= r_vis1 ? {r_rdata[8:6], r_rdata[8]} : 4'd0;
        r_grn  <= r_vis1 ? {r_rdata[5:3], r_rdata[5]} : 4'd0;
        r_blu  <= r_vis1 ? {r_rdata[2:0], r_rdata[2]} : 4'd0;
        r_hs   <= r_hs1;
        r_vs   <= r_vs1;
      end
    end
  end

  assign vga.oVGA_R  = r_red;
  assign vga.oVGA_G  = r_grn;
  assign vga.oVGA_B  = r_blu;
  assign vga.oVGA_HS = r_hs;
  assign vga.oVGA_VS = r_vs;

endmodule

// File: tb/tb_vga_ctrl.sv
// Self-checking bench for vga_ctrl: random framebuffer traffic against a position-based
// reference model of scan timing, 4x4 scaling, colour expansion and sync generation.
module tb_vga_ctrl;

  logic iCLK = 1'b0;
  logic iRST = 1'b1;

  vga_ctrl_if ifc ();

  vga_ctrl dut (
    .iCLK (iCLK),
    .iRST (iRST),
    .vga  (ifc)
  );

  always #10 iCLK = ~iCLK;

  int compared   = 0;
  int mismatched = 0;

  // Clock edges seen since the last reset release (1 = first edge after release).
  int clkN = 0;

  logic [8:0]  modelMem  [0:19199];
  bit          memKnown  [0:19199];
  logic [8:0]  readHist  [0:3];
  bit          readKnown [0:3];

  logic [13:0] obsPins;
  assign obsPins = {ifc.oVGA_R, ifc.oVGA_G, ifc.oVGA_B, ifc.oVGA_HS, ifc.oVGA_VS};

  function automatic logic [3:0] expand3(input logic [2:0] c);
    return {c, c[2]};
  endfunction

  // Pins after edge n show scan position p=(n-4)/2; colour is the memory word read for p.
  function automatic logic [13:0] expPins(input int n);
    int p, h, v;
    logic [8:0]  c;
    logic [11:0] rgb;
    logic hs, vs;
    if (n < 4) return {12'h000, 2'b11};
    p  = (n - 4) / 2;
    h  = p % 800;
    v  = (p / 800) % 525;
    hs = !(h >= 656 && h <= 751);
    vs = !(v >= 490 && v <= 491);
    c  = readHist[p % 4];
    rgb = (h < 640 && v < 480) ? {expand3(c[8:6]), expand3(c[5:3]), expand3(c[2:0])} : 12'h000;
    return {rgb, hs, vs};
  endfunction

  function automatic bit expKnown(input int n);
    if (n < 4) return 1'b1;
    return readKnown[((n - 4) / 2) % 4];
  endfunction

  task automatic setWrite(input int x, input int y, input logic [8:0] c);
    ifc.write_x = 8'(x);
    ifc.write_y = 8'(y);
    {ifc.write_r, ifc.write_g, ifc.write_b} = c;
  endtask

  task automatic idleWrite();
    setWrite(255, 255, 9'h000);
  endtask

  // Advance one clock, updating the model memory and the scan read history, then
  // land on the falling edge where outputs are sampled and inputs change.
  task automatic stepClk();
    int pr, hr, vr, a;
    @(posedge iCLK);
    if (!iRST) begin
      clkN++;
      if (clkN >= 2 && (clkN % 2) == 0) begin
        pr = (clkN - 2) / 2;
        hr = pr % 800;
        vr = (pr / 800) % 525;
        if (hr < 640 && vr < 480) begin
          a = (vr / 4) * 160 + hr / 4;
          readHist[pr % 4]  = modelMem[a];
          readKnown[pr % 4] = memKnown[a];
        end else begin
          readHist[pr % 4]  = 9'h000;
          readKnown[pr % 4] = 1'b1;
        end
      end
      if (ifc.write_x < 8'd160 && ifc.write_y < 8'd120) begin
        a = int'(ifc.write_y) * 160 + int'(ifc.write_x);
        modelMem[a] = {ifc.write_r, ifc.write_g, ifc.write_b};
        memKnown[a] = 1'b1;
      end
    end
    @(negedge iCLK);
  endtask

  task automatic restartScan();
    iRST = 1'b1;
    clkN = 0;
    repeat (3) stepClk();
    iRST = 1'b0;
  endtask

  task automatic test_fill();
    iRST = 1'b0;
    for (int y = 0; y < 4; y++) begin
      for (int x = 0; x < 160; x++) begin
        setWrite(x, y, 9'($urandom_range(0, 510)));
        stepClk();
        if (expKnown(clkN)) begin
          compared++;
          if (obsPins !== expPins(clkN)) begin
            mismatched++;
            $display("[TB] FAIL fill_scan n=%0d got %h expected %h", clkN, obsPins, expPins(clkN));
          end
        end
      end
    end
    idleWrite();
  endtask

  task automatic test_reset();
    int firstLow;
    repeat ($urandom_range(200, 700)) begin
      stepClk();
      if (expKnown(clkN)) begin
        compared++;
        if (obsPins !== expPins(clkN)) begin
          mismatched++;
          $display("[TB] FAIL prereset_scan n=%0d got %h expected %h", clkN, obsPins, expPins(clkN));
        end
      end
    end
    @(posedge iCLK);
    #3 iRST = 1'b1;
    clkN = 0;
    #1;
    compared++;
    if (obsPins !== 14'h0003) begin
      mismatched++;
      $display("[TB] FAIL reset_async got %h expected %h", obsPins, 14'h0003);
    end
    @(negedge iCLK);
    for (int i = 0; i < 6; i++) begin
      setWrite($urandom_range(0, 159), 0, 9'h1FF);
      stepClk();
      compared++;
      if (obsPins !== 14'h0003) begin
        mismatched++;
        $display("[TB] FAIL reset_hold got %h expected %h", obsPins, 14'h0003);
      end
    end
    idleWrite();
    iRST = 1'b0;
    firstLow = -1;
    for (int i = 0; i < 1500; i++) begin
      stepClk();
      if (expKnown(clkN)) begin
        compared++;
        if (obsPins !== expPins(clkN)) begin
          mismatched++;
          $display("[TB] FAIL release_scan n=%0d got %h expected %h", clkN, obsPins, expPins(clkN));
        end
      end
      if (firstLow < 0 && ifc.oVGA_HS === 1'b0) firstLow = clkN;
    end
    compared++;
    if (firstLow != 1316) begin
      mismatched++;
      $display("[TB] FAIL hs_first_fall got edge %0d expected edge %0d", firstLow, 1316);
    end
  endtask

  task automatic test_colour_expansion();
    int p;
    setWrite(0, 0, {3'd4, 3'd1, 3'd3});
    stepClk();
    idleWrite();
    restartScan();
    for (int i = 0; i < 4 * 1600 + 8; i++) begin
      stepClk();
      if (expKnown(clkN)) begin
        compared++;
        if (obsPins !== expPins(clkN)) begin
          mismatched++;
          $display("[TB] FAIL colour_scan n=%0d got %h expected %h", clkN, obsPins, expPins(clkN));
        end
      end
      if (clkN >= 4) begin
        p = (clkN - 4) / 2;
        if ((p % 800) < 4 && (p / 800) < 4) begin
          compared++;
          if (obsPins[13:2] !== 12'h926) begin
            mismatched++;
            $display("[TB] FAIL colour_expand h=%0d v=%0d got %h expected %h",
                     p % 800, p / 800, obsPins[13:2], 12'h926);
          end
        end
      end
    end
  endtask

  task automatic test_out_of_range();
    int p, h, v;
    setWrite(40, 0, 9'h000);  stepClk();
    setWrite(40, 1, 9'h000);  stepClk();
    setWrite(200, 0, 9'h1FF); stepClk();
    setWrite(5, 130, 9'h1FF); stepClk();
    setWrite(160, 0, 9'h1FF); stepClk();
    setWrite(0, 120, 9'h1FF); stepClk();
    setWrite(255, 1, 9'h1FF); stepClk();
    idleWrite();
    restartScan();
    for (int i = 0; i < 8 * 1600 + 8; i++) begin
      stepClk();
      if (expKnown(clkN)) begin
        compared++;
        if (obsPins !== expPins(clkN)) begin
          mismatched++;
          $display("[TB] FAIL oor_scan n=%0d got %h expected %h", clkN, obsPins, expPins(clkN));
        end
      end
      if (clkN >= 4) begin
        p = (clkN - 4) / 2;
        h = p % 800;
        v = p / 800;
        if (h >= 160 && h <= 163 && v < 8) begin
          compared++;
          if (obsPins[13:2] !== 12'h000) begin
            mismatched++;
            $display("[TB] FAIL oor_pixel h=%0d v=%0d got %h expected %h", h, v, obsPins[13:2], 12'h000);
          end
        end
      end
    end
  endtask

  task automatic test_pixel_scale();
    int p, h, v;
    setWrite(9, 1, 9'h000);  stepClk();
    setWrite(11, 1, 9'h000); stepClk();
    setWrite(10, 1, {3'd7, 3'd0, 3'd0}); stepClk();
    idleWrite();
    restartScan();
    for (int i = 0; i < 8 * 1600 + 8; i++) begin
      stepClk();
      if (expKnown(clkN)) begin
        compared++;
        if (obsPins !== expPins(clkN)) begin
          mismatched++;
          $display("[TB] FAIL scale_scan n=%0d got %h expected %h", clkN, obsPins, expPins(clkN));
        end
      end
      if (clkN >= 4) begin
        p = (clkN - 4) / 2;
        h = p % 800;
        v = p / 800;
        if (v >= 4 && v <= 7 && h >= 39 && h <= 44) begin
          compared++;
          if (obsPins[13:2] !== ((h >= 40 && h <= 43) ? 12'hF00 : 12'h000)) begin
            mismatched++;
            $display("[TB] FAIL scale_pixel h=%0d v=%0d got %h expected %h", h, v, obsPins[13:2],
                     ((h >= 40 && h <= 43) ? 12'hF00 : 12'h000));
          end
        end
      end
    end
  endtask

  task automatic test_blanking();
    int p, h, v;
    for (int x = 0; x < 160; x++) begin
      setWrite(x, 0, 9'h1FF);
      stepClk();
    end
    idleWrite();
    restartScan();
    for (int i = 0; i < 4 * 1600 + 8; i++) begin
      stepClk();
      if (expKnown(clkN)) begin
        compared++;
        if (obsPins !== expPins(clkN)) begin
          mismatched++;
          $display("[TB] FAIL blank_scan n=%0d got %h expected %h", clkN, obsPins, expPins(clkN));
        end
      end
      if (clkN >= 4) begin
        p = (clkN - 4) / 2;
        h = p % 800;
        v = p / 800;
        if (v < 4) begin
          compared++;
          if (obsPins[13:2] !== ((h < 640) ? 12'hFFF : 12'h000)) begin
            mismatched++;
            $display("[TB] FAIL blank_rgb h=%0d v=%0d got %h expected %h", h, v, obsPins[13:2],
                     ((h < 640) ? 12'hFFF : 12'h000));
          end
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    int sel;
    restartScan();
    for (int i = 0; i < 8 * 1600; i++) begin
      sel = $urandom_range(0, 9);
      if (sel < 7)      setWrite($urandom_range(0, 159), $urandom_range(0, 1), 9'($urandom_range(0, 511)));
      else if (sel < 9) setWrite($urandom_range(160, 255), $urandom_range(0, 119), 9'($urandom_range(0, 511)));
      else              setWrite($urandom_range(0, 255), $urandom_range(120, 255), 9'($urandom_range(0, 511)));
      stepClk();
      if (expKnown(clkN)) begin
        compared++;
        if (obsPins !== expPins(clkN)) begin
          mismatched++;
          $display("[TB] FAIL random_scan n=%0d got %h expected %h", clkN, obsPins, expPins(clkN));
        end
      end
    end
    idleWrite();
  endtask

  initial begin
    idleWrite();
    iRST = 1'b1;
    repeat (4) @(negedge iCLK);
    test_fill();
    test_reset();
    test_colour_expansion();
    test_out_of_range();
    test_pixel_scale();
    test_blanking();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
